// File: rtl/memory_bank_pkg.sv
// Shared types and default sizing for the memory bank and its storage array.
package memory_bank_pkg;

   localparam int DEFAULT_DATA_W = 64;
   localparam int DEFAULT_DEPTH  = 8;

   typedef enum logic {
      CLEARING = 1'b0,
      READY    = 1'b1
   } state_t;

endpackage

// File: rtl/memory_bank_array.sv
// Word storage with byte-masked write port and a registered read-data output.
module memory_bank_array
   import memory_bank_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_word,
   input  logic                out_load,
   input  logic [DATA_W-1:0]   out_data,
   output logic [DATA_W-1:0]   d_out
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] d_out_q;
   logic [DATA_W-1:0] d_out_d;

   // Contents are deliberately not reset; the owner zeroes them with a sweep.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if ({1'b0, rd_addr} < DEPTH_L) begin
         rd_word = mem_q[rd_addr];
      end
   end

   always_comb begin
      d_out_d = d_out_q;
      if (out_load) begin
         d_out_d = out_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_out_q <= '0;
      end else begin
         d_out_q <= d_out_d;
      end
   end

   assign d_out = d_out_q;

endmodule

// File: rtl/memory_bank.sv
// Memory bank top: clear-sweep FSM, request acceptance, read bypass and sticky range error.
module memory_bank
   import memory_bank_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int RD_BYPASS = 1,
   parameter int ADDR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [DATA_W-1:0]   D_IN,
   input  logic [ADDR_W-1:0]   ADDR,
   input  logic                R_ENABLE,
   input  logic                W_ENABLE,
   input  logic [DATA_W/8-1:0] BYTE_EN,
   input  logic                CLEAR,
   output logic [DATA_W-1:0]   D_OUT,
   output logic                R_VALID,
   output logic                BUSY,
   output logic                ERR
);

   localparam int              NB      = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                r_valid_q, r_valid_d;

   logic                in_range;
   logic                arr_wr_en;
   logic [ADDR_W-1:0]   arr_wr_addr;
   logic [DATA_W-1:0]   arr_wr_data;
   logic [NB-1:0]       arr_wr_be;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   merged;
   logic                out_load;
   logic [DATA_W-1:0]   out_data;

   assign in_range = ({1'b0, ADDR} < DEPTH_L);

   // Sweep and normal accesses share the single array write port.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      r_valid_d   = 1'b0;
      arr_wr_en   = 1'b0;
      arr_wr_addr = ADDR;
      arr_wr_data = D_IN;
      arr_wr_be   = BYTE_EN;
      out_load    = 1'b0;
      out_data    = rd_word;
      merged      = rd_word;
      for (int i = 0; i < NB; i++) begin
         if (BYTE_EN[i]) begin
            merged[8*i +: 8] = D_IN[8*i +: 8];
         end
      end
      case (state_q)
         CLEARING: begin
            arr_wr_en   = !RESET;
            arr_wr_addr = cnt_q;
            arr_wr_data = '0;
            arr_wr_be   = '1;
            if (cnt_q == LAST) begin
               state_d = READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         READY: begin
            if (CLEAR) begin
               state_d = CLEARING;
               cnt_d   = '0;
               err_d   = 1'b0;
            end else if (R_ENABLE || W_ENABLE) begin
               if (!in_range) begin
                  err_d = 1'b1;
               end else begin
                  arr_wr_en = W_ENABLE;
                  out_load  = R_ENABLE;
                  r_valid_d = R_ENABLE;
                  if (W_ENABLE && (RD_BYPASS != 0)) begin
                     out_data = merged;
                  end
               end
            end
         end
         default: state_d = CLEARING;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= CLEARING;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         r_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         r_valid_q <= r_valid_d;
      end
   end

   memory_bank_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk      (CLK),
      .rst      (RESET),
      .wr_en    (arr_wr_en),
      .wr_addr  (arr_wr_addr),
      .wr_data  (arr_wr_data),
      .wr_be    (arr_wr_be),
      .rd_addr  (ADDR),
      .rd_word  (rd_word),
      .out_load (out_load),
      .out_data (out_data),
      .d_out    (D_OUT)
   );

   assign R_VALID = r_valid_q;
   assign BUSY    = (state_q == CLEARING);
   assign ERR     = err_q;

endmodule

// File: tb/tb_memory_bank.sv
// Bench for memory_bank: two instances (8 words with bypass, 6 words without) driven in lockstep.
module tb_memory_bank;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [63:0] D_IN;
   logic [2:0]  ADDR;
   logic        R_ENABLE;
   logic        W_ENABLE;
   logic [7:0]  BYTE_EN;
   logic        CLEAR;

   logic [63:0] doutA, doutB;
   logic        validA, validB, busyA, busyB, errA, errB;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model: per instance, remaining sweep cycles plus word contents.
   int          mDepth  [2] = '{8, 6};
   bit          mBypass [2] = '{1'b1, 1'b0};
   int          mBusy   [2];
   logic [63:0] mMem    [2][8];
   logic [63:0] mDout   [2];
   logic        mValid  [2];
   logic        mErr    [2];

   always #5 CLK = ~CLK;

   memory_bank #(.DATA_W(64), .DEPTH(8), .RD_BYPASS(1)) dutA (
      .CLK(CLK), .RESET(RESET), .D_IN(D_IN), .ADDR(ADDR), .R_ENABLE(R_ENABLE),
      .W_ENABLE(W_ENABLE), .BYTE_EN(BYTE_EN), .CLEAR(CLEAR),
      .D_OUT(doutA), .R_VALID(validA), .BUSY(busyA), .ERR(errA)
   );

   memory_bank #(.DATA_W(64), .DEPTH(6), .RD_BYPASS(0)) dutB (
      .CLK(CLK), .RESET(RESET), .D_IN(D_IN), .ADDR(ADDR), .R_ENABLE(R_ENABLE),
      .W_ENABLE(W_ENABLE), .BYTE_EN(BYTE_EN), .CLEAR(CLEAR),
      .D_OUT(doutB), .R_VALID(validB), .BUSY(busyB), .ERR(errB)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mBusy[i]  = mDepth[i];
         mDout[i]  = '0;
         mValid[i] = 1'b0;
         mErr[i]   = 1'b0;
      end
   endtask

   task automatic modelEdge();
      logic [63:0] oldWord, newWord;
      int a;
      a = int'(ADDR);
      for (int i = 0; i < 2; i++) begin
         if (mBusy[i] > 0) begin
            mMem[i][mDepth[i] - mBusy[i]] = '0;
            mBusy[i]--;
            mValid[i] = 1'b0;
         end else if (CLEAR) begin
            mBusy[i]  = mDepth[i];
            mErr[i]   = 1'b0;
            mValid[i] = 1'b0;
         end else if ((R_ENABLE || W_ENABLE) && a >= mDepth[i]) begin
            mErr[i]   = 1'b1;
            mValid[i] = 1'b0;
         end else begin
            oldWord = mMem[i][a];
            newWord = oldWord;
            for (int b = 0; b < 8; b++) begin
               if (BYTE_EN[b]) newWord[8*b +: 8] = D_IN[8*b +: 8];
            end
            if (W_ENABLE) mMem[i][a] = newWord;
            if (R_ENABLE) begin
               mDout[i]  = (W_ENABLE && mBypass[i]) ? newWord : oldWord;
               mValid[i] = 1'b1;
            end else begin
               mValid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic checkOutput();
      check("A.dout",  doutA,  mDout[0]);
      check("A.valid", {63'd0, validA}, {63'd0, mValid[0]});
      check("A.busy",  {63'd0, busyA},  {63'd0, mBusy[0] > 0});
      check("A.err",   {63'd0, errA},   {63'd0, mErr[0]});
      check("B.dout",  doutB,  mDout[1]);
      check("B.valid", {63'd0, validB}, {63'd0, mValid[1]});
      check("B.busy",  {63'd0, busyB},  {63'd0, mBusy[1] > 0});
      check("B.err",   {63'd0, errB},   {63'd0, mErr[1]});
   endtask

   task automatic applyStimulus(input logic ren, input logic wen, input logic [2:0] addr,
                                input logic [63:0] din, input logic [7:0] be, input logic clr);
      R_ENABLE = ren;
      W_ENABLE = wen;
      ADDR     = addr;
      D_IN     = din;
      BYTE_EN  = be;
      CLEAR    = clr;
      @(posedge CLK);
      modelEdge();
      @(negedge CLK);
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 8'd0, 1'b0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 8; w++) mMem[i][w] = '0;
      RESET = 1'b1; D_IN = '0; ADDR = '0; R_ENABLE = 1'b0; W_ENABLE = 1'b0;
      BYTE_EN = '0; CLEAR = 1'b0;
      modelReset();
      repeat (2) @(negedge CLK);
      checkOutput();

      // Reads during the power-up sweep are ignored; then every word reads back zero.
      RESET = 1'b0;
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 3'(k), 64'd0, 8'd0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 3'(k), 64'd0, 8'd0, 1'b0);
         check("zero_after_sweep", doutA, 64'd0);
      end
      applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 8'd0, 1'b1);
      idle(8);

      // Full write then read back.
      applyStimulus(1'b0, 1'b1, 3'd0, 64'h1, 8'hFF, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'd0, 64'd0, 8'd0, 1'b0);
      check("wr_rd_word0", doutA, 64'h1);
      check("wr_rd_valid", {63'd0, validA}, 64'd1);

      // Partial byte write.
      applyStimulus(1'b0, 1'b1, 3'd3, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
      applyStimulus(1'b0, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'd3, 64'd0, 8'd0, 1'b0);
      check("byte_en_A", doutA, 64'h1111_1111_FFFF_FFFF);
      check("byte_en_B", doutB, 64'h1111_1111_FFFF_FFFF);

      // Simultaneous read and write to the same word.
      applyStimulus(1'b1, 1'b1, 3'd0, 64'h2, 8'hFF, 1'b0);
      check("bypass_new", doutA, 64'h2);
      check("nobypass_old", doutB, 64'h1);
      applyStimulus(1'b1, 1'b0, 3'd0, 64'd0, 8'd0, 1'b0);
      check("later_read_A", doutA, 64'h2);
      check("later_read_B", doutB, 64'h2);

      // Top address and out-of-range access, then CLEAR.
      applyStimulus(1'b1, 1'b0, 3'd7, 64'd0, 8'd0, 1'b0);
      check("top_addr_errA", {63'd0, errA}, 64'd0);
      applyStimulus(1'b0, 1'b1, 3'd6, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 1'b0);
      check("oor_errB", {63'd0, errB}, 64'd1);
      applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 8'd0, 1'b1);
      check("clear_errB", {63'd0, errB}, 64'd0);
      n = 1;
      while (busyB && n < 50) begin
         applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 8'd0, 1'b0);
         if (busyB) n++;
      end
      check("clear_cycles_B", 64'(n), 64'd6);
      idle(3);
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 3'(k), 64'd0, 8'd0, 1'b0);

      // Random traffic against the model.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                       {$urandom, $urandom}, 8'($urandom), ($urandom_range(0, 19) == 0));
      end
      idle(9);

      // Reset pulse in the third cycle of a sweep restarts it from scratch.
      applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 8'd0, 1'b1);
      idle(2);
      #2 RESET = 1'b1;
      #1 modelReset();
      checkOutput();
      #1 RESET = 1'b0;
      n = 0;
      while (n < 50) begin
         applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 8'd0, 1'b0);
         n++;
         if (!busyA) break;
      end
      check("resweep_cycles_A", 64'(n), 64'd8);
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 3'(k), 64'd0, 8'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
